// File: rtl/rob_multi_commit_pkg.sv
// Shared types for the reorder buffer: register index, exception code and the
// per-entry status record kept alongside the pc/data arrays.
package rob_multi_commit_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int ROB_DEPTH_DEF = 8;

  typedef logic [4:0] RegFile_t;
  typedef logic [3:0] ExpCode_t;

  localparam ExpCode_t EXP_ILLEGAL = 4'd2;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     br;
    logic     exp;
    ExpCode_t exp_code;
    logic     pred_miss;
    RegFile_t rd;
  } RobEntry_t;

endpackage

// File: rtl/rob_multi_commit_sel.sv
// In-order commit slot selection: retires a contiguous run of done entries
// from head, stopping at the first exception or mispredict.
module rob_multi_commit_sel
  import rob_multi_commit_pkg::*;
#(
  parameter int COM_WIDTH = 2
) (
  input  RobEntry_t [COM_WIDTH-1:0] i_ent,
  output logic [COM_WIDTH-1:0]      o_ret,
  output logic                      o_exp,
  output ExpCode_t                  o_exp_code,
  output logic                      o_flush
);

  logic [COM_WIDTH-1:0] w_rdy;
  logic [COM_WIDTH-1:0] w_spec;
  logic                 w_unused;

  always_comb begin
    w_unused = 1'b0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      w_rdy[k]  = i_ent[k].valid && i_ent[k].done;
      w_spec[k] = i_ent[k].exp || i_ent[k].pred_miss;
      w_unused  = w_unused ^ i_ent[k].br ^ (^i_ent[k].rd) ^ (^i_ent[k].exp_code);
    end
  end

  // An excepting head entry is reported, not retired; a mispredict retires then flushes.
  always_comb begin
    logic chain;
    o_ret    = '0;
    chain    = w_rdy[0] && !i_ent[0].exp;
    o_ret[0] = chain;
    for (int k = 1; k < COM_WIDTH; k++) begin
      chain    = chain && w_rdy[k] && !w_spec[k-1] && !w_spec[k];
      o_ret[k] = chain;
    end
  end

  assign o_exp      = w_rdy[0] && i_ent[0].exp;
  assign o_exp_code = o_exp ? i_ent[0].exp_code : '0;
  assign o_flush    = w_rdy[0] && w_spec[0];

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: single dispatch, WB_PORTS writebacks, up to COM_WIDTH
// in-order commits per cycle, with exception/mispredict flush.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int  DATA      = DATA_W,
  parameter int  ADDR      = ADDR_W,
  parameter int  ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int  WB_PORTS  = 2,
  parameter int  COM_WIDTH = 2,
  localparam int ROB       = $clog2(ROB_DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               dec_e_,
  input  logic [ADDR-1:0]                    dec_pc,
  input  RegFile_t                           dec_rd,
  input  logic                               dec_br_,
  input  logic                               dec_invalid,
  output logic [ROB-1:0]                     dec_rob_id,
  output logic                               rob_busy,
  output logic [ROB:0]                       rob_count,
  input  logic [WB_PORTS-1:0]                wb_e_,
  input  logic [WB_PORTS-1:0][ROB-1:0]       wb_rob_id,
  input  logic [WB_PORTS-1:0][DATA-1:0]      wb_data,
  input  logic [WB_PORTS-1:0]                wb_exp_,
  input  ExpCode_t [WB_PORTS-1:0]            wb_exp_code,
  input  logic [WB_PORTS-1:0]                wb_pred_miss_,
  output logic [COM_WIDTH-1:0]               commit_e_,
  output logic [COM_WIDTH-1:0][ADDR-1:0]     commit_pc,
  output RegFile_t [COM_WIDTH-1:0]           commit_rd,
  output logic [COM_WIDTH-1:0][DATA-1:0]     commit_data,
  output logic [COM_WIDTH-1:0][ROB-1:0]      commit_rob_id,
  output logic                               commit_exp_,
  output ExpCode_t                           commit_exp_code,
  output logic                               flush_
);

  localparam int PW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

  RobEntry_t       r_ent  [ROB_DEPTH];
  logic [ADDR-1:0] r_pc   [ROB_DEPTH];
  logic [DATA-1:0] r_data [ROB_DEPTH];
  logic [ROB-1:0]  r_head;
  logic [ROB-1:0]  r_tail;
  logic [ROB:0]    r_count;

  logic                          w_busy;
  logic                          w_disp;
  logic                          w_flush;
  logic                          w_exp;
  ExpCode_t                      w_exp_code;
  logic [COM_WIDTH-1:0]          w_ret;
  logic [ROB:0]                  w_ncom;
  logic [COM_WIDTH-1:0][ROB-1:0] w_sel_id;
  RobEntry_t [COM_WIDTH-1:0]     w_sel_ent;
  logic [ROB_DEPTH-1:0]          w_wb_hit;
  logic [ROB_DEPTH-1:0][PW-1:0]  w_wb_port;
  RobEntry_t                     w_new;

  // Busy looks only at the registered count, so same-cycle commits never admit a dispatch.
  assign w_busy = (r_count == (ROB+1)'(ROB_DEPTH));
  assign w_disp = !dec_e_ && !w_busy && !w_flush;

  always_comb begin
    w_new           = '0;
    w_new.valid     = 1'b1;
    w_new.br        = !dec_br_;
    w_new.done      = dec_invalid;
    w_new.exp       = dec_invalid;
    w_new.exp_code  = EXP_ILLEGAL;
    w_new.rd        = dec_rd;
  end

  // Descending scan so the lowest-index port targeting an entry wins.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      w_wb_hit[i]  = 1'b0;
      w_wb_port[i] = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (!wb_e_[p] && wb_rob_id[p] == ROB'(i)) begin
          w_wb_hit[i]  = 1'b1;
          w_wb_port[i] = PW'(p);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < COM_WIDTH; k++) begin
      w_sel_id[k]  = r_head + ROB'(k);
      w_sel_ent[k] = r_ent[w_sel_id[k]];
    end
  end

  rob_multi_commit_sel #(.COM_WIDTH(COM_WIDTH)) u_sel (
    .i_ent      (w_sel_ent),
    .o_ret      (w_ret),
    .o_exp      (w_exp),
    .o_exp_code (w_exp_code),
    .o_flush    (w_flush)
  );

  always_comb begin
    w_ncom = '0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      w_ncom           = w_ncom + (ROB+1)'(w_ret[k]);
      commit_e_[k]     = !w_ret[k];
      commit_pc[k]     = w_ret[k] ? r_pc[w_sel_id[k]]   : '0;
      commit_data[k]   = w_ret[k] ? r_data[w_sel_id[k]] : '0;
      commit_rd[k]     = w_ret[k] ? w_sel_ent[k].rd     : '0;
      commit_rob_id[k] = w_ret[k] ? w_sel_id[k]         : '0;
    end
  end

  assign commit_exp_     = !w_exp;
  assign commit_exp_code = w_exp_code;
  assign flush_          = !w_flush;
  assign rob_busy        = w_busy;
  assign rob_count       = r_count;
  assign dec_rob_id      = r_tail;

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (w_wb_hit[i] && r_ent[i].valid) begin
          r_ent[i].done      <= 1'b1;
          r_ent[i].exp       <= !wb_exp_[w_wb_port[i]];
          r_ent[i].exp_code  <= wb_exp_code[w_wb_port[i]];
          r_ent[i].pred_miss <= !wb_pred_miss_[w_wb_port[i]];
        end
      end
      for (int k = 0; k < COM_WIDTH; k++) begin
        if (w_ret[k]) r_ent[w_sel_id[k]].valid <= 1'b0;
      end
      if (w_disp) r_ent[r_tail] <= w_new;
      r_head  <= r_head + w_ncom[ROB-1:0];
      r_tail  <= r_tail + ROB'(w_disp);
      r_count <= r_count + (ROB+1)'(w_disp) - w_ncom;
    end
  end

  // Payload storage is never reset; unretired slots are masked at the outputs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (w_wb_hit[i] && r_ent[i].valid && !w_flush) r_data[i] <= wb_data[w_wb_port[i]];
    end
    if (w_disp) r_pc[r_tail] <= dec_pc;
  end

endmodule

// File: doc/rob_multi_commit.md
ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

Interface
REQ-001 Parameters: DATA=`DataWidth (operand width); ADDR=`AddrWidth (PC width); ROB_DEPTH=`RobDepth (entries, power of 2, >=4); WB_PORTS=2 (writeback ports, 1..4); COM_WIDTH=2 (commit slots, 1..2); ROB=$clog2(ROB_DEPTH).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 dec_e_  in  1  dispatch request, active-low.
REQ-005 dec_pc  in  ADDR; dec_rd  in  RegFile_t; dec_br_  in  1  (branch/jump, active-low); dec_invalid  in  1  (illegal instruction).
REQ-006 dec_rob_id  out  ROB  entry index assigned to the current dispatch (tail).
REQ-007 rob_busy  out  1  high when ROB full; dispatch not accepted.
REQ-008 rob_count  out  ROB+1  occupied entries.
REQ-009 wb_e_ [WB_PORTS]  in  active-low; wb_rob_id [WB_PORTS][ROB]; wb_data [WB_PORTS][DATA]; wb_exp_ [WB_PORTS]; wb_exp_code [WB_PORTS] ExpCode_t; wb_pred_miss_ [WB_PORTS].
REQ-010 commit_e_ [COM_WIDTH]  out  active-low retire per slot; commit_pc, commit_rd, commit_data, commit_rob_id  out  per slot.
REQ-011 commit_exp_  out  1  active-low; commit_exp_code  out  ExpCode_t; flush_  out  1  active-low pipeline flush.

Function
REQ-012 Circular buffer with head, tail (ROB bits, wrap modulo ROB_DEPTH) and count; full = count==ROB_DEPTH, empty = count==0.
REQ-013 rob_busy is derived from registered count only; commits in the same cycle do not unblock a dispatch.
REQ-014 Dispatch accepted when dec_e_=0, rob_busy=0, flush_=1: entry[tail] <= valid, pc, rd, br, done=dec_invalid, exp=dec_invalid with code illegal instruction; tail++.
REQ-015 Dispatch while full or in a flush cycle is dropped; no state change.
REQ-016 Writeback port p with wb_e_[p]=0 to a valid entry sets done, stores data, latches exp/code and pred_miss; writeback to an invalid entry is ignored.
REQ-017 Same wb_rob_id on several ports in one cycle: lowest-index port wins.
REQ-018 Commit outputs are combinational from registered state; writeback in cycle N is committable in N+1; dispatch in N is committable no earlier than N+1 (dec_invalid) or N+2 (writeback path).
REQ-019 Slot 0 commits entry[head] if valid and done; slot k commits entry[head+k] only if slot k-1 committed, entry valid and done, and neither entry has exp or pred_miss set.
REQ-020 Entry with exp set commits only in slot 0: commit_e_[0]=1 (not retired), commit_exp_=0, commit_exp_code=code, flush_=0.
REQ-021 Entry with pred_miss set commits only in slot 0: commit_e_[0]=0, flush_=0.
REQ-022 head += number of commits; count_next = count + accepted dispatch - commits.
REQ-023 Flush cycle: next cycle all valid bits cleared, head=tail=count=0; writebacks in the flush cycle are discarded.
REQ-024 commit_data, commit_pc, commit_rd, commit_rob_id are zero in any slot whose commit_e_ is 1.

Reset
REQ-025 reset=1 at a clock edge: head=tail=count=0, all valid/done/exp/miss cleared; overrides dispatch, writeback, flush in that cycle.
REQ-026 Reset outputs: commit_e_ all 1, commit_exp_=1, commit_exp_code=0, flush_=1, rob_busy=0, rob_count=0, dec_rob_id=0, commit data/pc/rd/rob_id all 0.
REQ-027 Data array is not reset; it is masked by REQ-024.

Structure
REQ-028 RobEntry_t (valid, done, br, exp, exp_code, pred_miss, pc, rd) and ROB_DEPTH defaults live in shared header rob.svh; RegFile_t and ExpCode_t reused from existing headers.
REQ-029 Commit selection is sub-module rob_commit_sel (combinational, COM_WIDTH slots); data storage reuses regfile with WRITE=WB_PORTS, READ=COM_WIDTH.

Verification (ROB_DEPTH=8, WB_PORTS=2, COM_WIDTH=2)
REQ-030 Dispatch 8 with no writeback -> rob_busy=1, rob_count=8, 9th dispatch dropped, dec_rob_id stays 0 (wrapped).
REQ-031 Dispatch ids 0,1; writeback both same cycle on ports 0,1 -> next cycle commit_e_=2'b00, ids 0,1, head=2, count=0.
REQ-032 Writeback id 1 before id 0 -> nothing commits until id 0 written; then both commit in one cycle.
REQ-033 Id 0 done, id 1 done with wb_exp_=0 code 5 -> cycle 1 commits id 0 only; cycle 2 commit_e_[0]=1, commit_exp_=0, code 5, flush_=0; cycle 3 count=0, head=tail=0.
REQ-034 Both ports write id 3 with data 0xA and 0xB -> committed data 0xA.
REQ-035 Assert reset while count=5 and flush_ pending -> next cycle all reset outputs per REQ-026, no flush_ pulse.
